// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one 1-bit slice (AND/OR/XOR/full-add) is reused across
// WIDTH clocks, LSB first, with operands latched on a start/done handshake.
module bit_serial_alu_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_OR = 3'b001, OP_XOR = 3'b010,
    OP_ADD = 3'b011, OP_SUB = 3'b100
  } op_t;

  state_t             state_q;
  op_t                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_sr_q, b_sr_q, res_sr_q;
  logic               busy_q, done_q, cout_q, ovf_q, zero_q, err_q;
  logic [WIDTH-1:0]   result_q;

  logic               arith, legal, b_bit, bit_d, carry_d, last;
  logic [WIDTH-1:0]   res_d;

  // Single slice: SUB is an add with b inverted and the carry seeded to 1.
  always_comb begin
    arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    legal   = (op_q <= OP_SUB);
    b_bit   = b_sr_q[0] ^ (op_q == OP_SUB);
    bit_d   = 1'b0;
    carry_d = carry_q;
    case (op_q)
      OP_AND:         bit_d = a_sr_q[0] & b_bit;
      OP_OR:          bit_d = a_sr_q[0] | b_bit;
      OP_XOR:         bit_d = a_sr_q[0] ^ b_bit;
      OP_ADD, OP_SUB: bit_d = a_sr_q[0] ^ b_bit ^ carry_q;
      default:        bit_d = 1'b0;
    endcase
    if (arith)
      carry_d = (a_sr_q[0] & b_bit) | (a_sr_q[0] & carry_q) | (b_bit & carry_q);
    res_d = {bit_d, res_sr_q[WIDTH-1:1]};
    last  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q  <= S_RUN;
          op_q     <= op_t'(op);
          a_sr_q   <= a;
          b_sr_q   <= b;
          res_sr_q <= '0;
          carry_q  <= (op == OP_SUB);
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          result_q <= '0;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
          zero_q   <= 1'b0;
          err_q    <= 1'b0;
        end
        S_RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_d;
          carry_q  <= carry_d;
          if (last) begin
            state_q  <= S_DONE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            cout_q   <= arith & carry_d;
            ovf_q    <= arith & (carry_q ^ carry_d);
            zero_q   <= (res_d == '0);
            err_q    <= ~legal;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule
